prefetch_rob_param: RTL and testbench
=====================================

Name: prefetch_rob_param

Overview:
- Parametrised reorder buffer for read prefetch traffic in the AFU.
- Hands out tags in issue order and accepts completions tagged in any order.
- Releases data strictly in issue order through a valid/ready stream.
- Generalises the fixed prefetch reorder buffer: configurable depth and width, occupancy reporting, and detection of illegal completions.

Parameters:
- DEPTH, 32, number of entries; power of two, at least 2
- DATA_W, 512, completion payload width in bits (one cache line)
- TAG_W, log2(DEPTH), tag width; derived, never overridden

Ports:
- clk  in  1  single clock; all logic on rising edge
- resetb  in  1  synchronous, active-high reset
- alloc_req  in  1  requester asks for a tag this cycle
- alloc_gnt  out  1  tag granted this cycle
- alloc_tag  out  TAG_W  tag granted; valid when alloc_gnt=1
- cpl_valid  in  1  completion present
- cpl_tag  in  TAG_W  tag of the completion
- cpl_data  in  DATA_W  completion payload
- out_valid  out  1  in-order data available
- out_ready  in  1  consumer accepts data
- out_data  out  DATA_W  data of the oldest entry
- out_tag  out  TAG_W  tag of the oldest entry
- occupancy  out  TAG_W+1  tags in flight (allocated, not yet drained)
- full  out  1  occupancy == DEPTH
- empty  out  1  occupancy == 0
- cpl_err  out  1  one-cycle pulse on an illegal completion
- cpl_err_sticky  out  1  latched cpl_err; cleared only by reset

Behaviour:
- State
  - head and tail pointers, each TAG_W+1 bits with a wrap bit.
  - Per-entry allocated and filled bit vectors.
  - Data array of DEPTH x DATA_W registers.
- Reset (resetb=1 at an edge)
  - head=tail=0; all allocated and filled bits cleared.
  - Outputs after reset: alloc_gnt=0 unless alloc_req=1; out_valid=0, occupancy=0, full=0, empty=1, cpl_err=0, cpl_err_sticky=0.
  - Data array is not reset.
  - Reset mid-operation discards all in-flight tags. Completions arriving in the reset cycle are ignored and raise no error.
- Derived flags
  - occupancy = tail - head, modulo 2^(TAG_W+1).
  - full when the index bits match and the wrap bits differ; empty when the pointers are equal.
- Allocation (combinational grant)
  - alloc_gnt = alloc_req & ~full; alloc_tag = tail[TAG_W-1:0].
  - On a grant: set allocated[tail], clear filled[tail], increment tail.
  - When full, the grant is refused even if a drain occurs in the same cycle. No same-cycle bypass.
- Completion
  - Legal when cpl_valid & allocated[cpl_tag] & ~filled[cpl_tag].
  - Legal: write cpl_data into the entry and set filled at the edge.
  - Illegal (tag not allocated, or already filled): drop the data, assert cpl_err for the next cycle only, set cpl_err_sticky.
  - A completion to the tag being drained in the same cycle is illegal, because that entry is already filled.
- Output
  - out_valid = ~empty & filled[head]; out_data = data[head]; out_tag = head[TAG_W-1:0]. All are driven from registers.
  - Latency: a completion accepted at edge N to the head entry gives out_valid=1 in cycle N+1, after 1 clock.
  - A transfer occurs when out_valid & out_ready. It clears allocated[head] and filled[head] and increments head.
  - out_data must stay stable while out_valid=1 and out_ready=0.
- Simultaneous events
  - Alloc, legal completion and drain may all happen in one cycle to distinct entries; each updates independently.
  - occupancy changes by +1, -1 or 0 accordingly.
  - Pointers wrap modulo 2^(TAG_W+1); tags wrap DEPTH-1 -> 0.

Test Plan (DEPTH=4, DATA_W=16):
- Reset, then alloc_req=1 for 4 cycles:
  - tags 0,1,2,3 granted; full=1 and occupancy=4.
  - 5th request: alloc_gnt=0.
- Completions in order 2,0,3,1 with data 0xA2,0xA0,0xA3,0xA1, out_ready=1:
  - after tag 0 completes, out 0xA0 (tag 0) the next cycle;
  - nothing is released while waiting for tag 1;
  - after tag 1 completes, outputs 0xA1,0xA2,0xA3 in consecutive cycles; empty=1 at the end.
- Full with head filled, alloc_req=1 and out_ready=1 in the same cycle:
  - drain occurs, grant refused;
  - the next cycle grants tag 0 (wrap); occupancy returns to 4.
- Completion to an unallocated tag 2 after reset, then a duplicate completion to filled tag 0:
  - cpl_err pulses for 1 cycle each; cpl_err_sticky=1;
  - the stored value of tag 0 is unchanged.
- Backpressure: head filled with 0x55, out_ready=0 for 5 cycles → out_valid=1 and out_data=0x55 held, occupancy constant.
- Assert resetb with 3 tags in flight and cpl_valid=1 → next cycle empty=1, out_valid=0, cpl_err=0; the next alloc grants tag 0.

Source files
------------

// File: rtl/prefetch_rob_param.sv
// Reorder buffer for read prefetch traffic. Tags are handed out in issue order,
// completions arrive in any order, and data leaves in issue order on a valid/ready stream.
module prefetch_rob_param #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 512,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cpl_valid,
    input  logic [TAG_W-1:0]  cpl_tag,
    input  logic [DATA_W-1:0] cpl_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic [TAG_W:0]    occupancy,
    output logic              full,
    output logic              empty,
    output logic              cpl_err,
    output logic              cpl_err_sticky
);

    localparam logic [TAG_W:0] PTR_ONE = 1;

    logic [TAG_W:0]    head;
    logic [TAG_W:0]    tail;
    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;
    logic [DEPTH-1:0]  allocated;
    logic [DEPTH-1:0]  filled;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic              err_q;
    logic              sticky_q;
    logic              cpl_ok;
    logic              drain;

    assign head_idx  = head[TAG_W-1:0];
    assign tail_idx  = tail[TAG_W-1:0];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign occupancy = tail - head;
    assign full      = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
    assign empty     = (head == tail);

    assign alloc_gnt = alloc_req & ~full;
    assign alloc_tag = tail_idx;

    assign cpl_ok    = cpl_valid & allocated[cpl_tag] & ~filled[cpl_tag];

    assign out_valid = ~empty & filled[head_idx];
    assign out_data  = data_q[head_idx];
    assign out_tag   = head_idx;
    assign drain     = out_valid & out_ready;

    assign cpl_err        = err_q;
    assign cpl_err_sticky = sticky_q;

    // Grant, completion and drain always hit distinct entries, so their
    // per-entry bit updates never collide.
    always_ff @(posedge clk) begin
        if (resetb) begin
            head      <= '0;
            tail      <= '0;
            allocated <= '0;
            filled    <= '0;
            err_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            if (alloc_gnt) begin
                allocated[tail_idx] <= 1'b1;
                filled[tail_idx]    <= 1'b0;
                tail                <= tail + PTR_ONE;
            end
            if (cpl_ok) begin
                filled[cpl_tag] <= 1'b1;
            end
            if (drain) begin
                allocated[head_idx] <= 1'b0;
                filled[head_idx]    <= 1'b0;
                head                <= head + PTR_ONE;
            end
            err_q <= cpl_valid & ~cpl_ok;
            if (cpl_valid & ~cpl_ok) begin
                sticky_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb && cpl_ok) begin
            data_q[cpl_tag] <= cpl_data;
        end
    end

endmodule

// File: tb/tb_prefetch_rob_param.sv
// Self-checking bench for prefetch_rob_param: directed scenarios with literal
// expectations, then random traffic compared against a queue-based model.
module tb_prefetch_rob_param;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 16;
    localparam int TAG_W  = 2;

    logic              clk = 1'b0;
    logic              resetb;
    logic              alloc_req;
    logic              alloc_gnt;
    logic [TAG_W-1:0]  alloc_tag;
    logic              cpl_valid;
    logic [TAG_W-1:0]  cpl_tag;
    logic [DATA_W-1:0] cpl_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [TAG_W:0]    occupancy;
    logic              full;
    logic              empty;
    logic              cpl_err;
    logic              cpl_err_sticky;

    int checks   = 0;
    int failures = 0;

    // Model: ordered list of in-flight tags plus per-tag fill state and data.
    int                mq[$];
    bit                mfilled [DEPTH];
    logic [DATA_W-1:0] mdata   [DEPTH];
    int                mnext;
    bit                merr;
    bit                msticky;
    bit                mvalid = 1'b0;
    bit                m_gnt;
    bit                m_legal;
    bit                m_drain;
    bit                m_inq;
    int                m_head;

    prefetch_rob_param #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .resetb         (resetb),
        .alloc_req      (alloc_req),
        .alloc_gnt      (alloc_gnt),
        .alloc_tag      (alloc_tag),
        .cpl_valid      (cpl_valid),
        .cpl_tag        (cpl_tag),
        .cpl_data       (cpl_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_tag        (out_tag),
        .occupancy      (occupancy),
        .full           (full),
        .empty          (empty),
        .cpl_err        (cpl_err),
        .cpl_err_sticky (cpl_err_sticky)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs just after a rising edge, then returns at the
    // falling edge so the caller can inspect that cycle's outputs.
    task automatic applyStimulus(input bit rst, input bit req, input bit cv,
                                 input int tag, input int data, input bit rdy);
        @(posedge clk);
        #1;
        resetb    = rst;
        alloc_req = req;
        cpl_valid = cv;
        cpl_tag   = TAG_W'(tag);
        cpl_data  = DATA_W'(data);
        out_ready = rdy;
        @(negedge clk);
    endtask

    function automatic bit modelOutValid();
        return (mq.size() > 0) && mfilled[mq[0]];
    endfunction

    always @(posedge clk) begin
        if (resetb) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) mfilled[i] = 1'b0;
            mnext   = 0;
            merr    = 1'b0;
            msticky = 1'b0;
            mvalid  = 1'b1;
        end else if (mvalid) begin
            m_gnt = alloc_req && (mq.size() < DEPTH);
            m_inq = 1'b0;
            foreach (mq[i]) if (mq[i] == int'(cpl_tag)) m_inq = 1'b1;
            m_legal = cpl_valid && m_inq && !mfilled[cpl_tag];
            m_drain = modelOutValid() && out_ready;
            merr    = cpl_valid && !m_legal;
            if (merr) msticky = 1'b1;
            if (m_legal) begin
                mfilled[cpl_tag] = 1'b1;
                mdata[cpl_tag]   = cpl_data;
            end
            if (m_drain) begin
                m_head          = mq.pop_front();
                mfilled[m_head] = 1'b0;
            end
            if (m_gnt) begin
                mq.push_back(mnext);
                mfilled[mnext] = 1'b0;
                mnext          = (mnext + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checkOutput("m_occupancy", 32'(occupancy), 32'(mq.size()));
            checkOutput("m_empty", 32'(empty), 32'(mq.size() == 0));
            checkOutput("m_full", 32'(full), 32'(mq.size() == DEPTH));
            checkOutput("m_out_valid", 32'(out_valid), 32'(modelOutValid()));
            checkOutput("m_cpl_err", 32'(cpl_err), 32'(merr));
            checkOutput("m_cpl_err_sticky", 32'(cpl_err_sticky), 32'(msticky));
            checkOutput("m_alloc_gnt", 32'(alloc_gnt), 32'(alloc_req && (mq.size() < DEPTH)));
            if (alloc_req && (mq.size() < DEPTH))
                checkOutput("m_alloc_tag", 32'(alloc_tag), 32'(mnext));
            if (modelOutValid()) begin
                checkOutput("m_out_tag", 32'(out_tag), 32'(mq[0]));
                checkOutput("m_out_data", 32'(out_data), 32'(mdata[mq[0]]));
            end
        end
    end

    initial begin
        resetb    = 1'b1;
        alloc_req = 1'b0;
        cpl_valid = 1'b0;
        cpl_tag   = '0;
        cpl_data  = '0;
        out_ready = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_empty", 32'(empty), 1);
        checkOutput("rst_occupancy", 32'(occupancy), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_full", 32'(full), 0);
        checkOutput("rst_cpl_err", 32'(cpl_err), 0);
        checkOutput("rst_sticky", 32'(cpl_err_sticky), 0);
        checkOutput("rst_alloc_gnt", 32'(alloc_gnt), 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkOutput("fill_gnt", 32'(alloc_gnt), 1);
            checkOutput("fill_tag", 32'(alloc_tag), 32'(i));
        end
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("full_gnt", 32'(alloc_gnt), 0);
        checkOutput("full_flag", 32'(full), 1);
        checkOutput("full_occupancy", 32'(occupancy), 4);

        applyStimulus(0, 0, 1, 2, 'hA2, 1);
        applyStimulus(0, 0, 1, 0, 'hA0, 1);
        checkOutput("ooo_wait0", 32'(out_valid), 0);
        applyStimulus(0, 0, 1, 3, 'hA3, 1);
        checkOutput("ooo_valid0", 32'(out_valid), 1);
        checkOutput("ooo_data0", 32'(out_data), 'hA0);
        checkOutput("ooo_tag0", 32'(out_tag), 0);
        applyStimulus(0, 0, 1, 1, 'hA1, 1);
        checkOutput("ooo_wait1", 32'(out_valid), 0);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1);
            checkOutput("ooo_valid", 32'(out_valid), 1);
            checkOutput("ooo_data", 32'(out_data), 32'('hA0 + i));
            checkOutput("ooo_tag", 32'(out_tag), 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ooo_empty", 32'(empty), 1);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 0);
            checkOutput("refill_tag", 32'(alloc_tag), 32'(i));
        end
        applyStimulus(0, 0, 1, 0, 'h77, 0);
        applyStimulus(0, 1, 0, 0, 0, 1);
        checkOutput("nobypass_valid", 32'(out_valid), 1);
        checkOutput("nobypass_gnt", 32'(alloc_gnt), 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("wrap_gnt", 32'(alloc_gnt), 1);
        checkOutput("wrap_tag", 32'(alloc_tag), 0);
        checkOutput("wrap_occ_before", 32'(occupancy), 3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("wrap_occ_after", 32'(occupancy), 4);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 'hDEAD, 0);
        checkOutput("unalloc_no_err_yet", 32'(cpl_err), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("unalloc_err", 32'(cpl_err), 1);
        checkOutput("unalloc_sticky", 32'(cpl_err_sticky), 1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("unalloc_err_pulse", 32'(cpl_err), 0);
        checkOutput("unalloc_sticky_hold", 32'(cpl_err_sticky), 1);
        applyStimulus(0, 0, 1, 0, 'h55, 0);
        applyStimulus(0, 0, 1, 0, 'hBEEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("dup_err", 32'(cpl_err), 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0);
            checkOutput("bp_valid", 32'(out_valid), 1);
            checkOutput("bp_data", 32'(out_data), 'h55);
            checkOutput("bp_occupancy", 32'(occupancy), 1);
        end

        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 1, 'h99, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("midrst_empty", 32'(empty), 1);
        checkOutput("midrst_valid", 32'(out_valid), 0);
        checkOutput("midrst_err", 32'(cpl_err), 0);
        checkOutput("midrst_tag", 32'(alloc_tag), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("midrst_occ", 32'(occupancy), 1);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 2,
                          $urandom_range(0, 99) < 45,
                          $urandom_range(0, 99) < 55,
                          int'($urandom_range(0, DEPTH - 1)),
                          int'($urandom_range(0, 65535)),
                          $urandom_range(0, 99) < 65);
        end

        applyStimulus(0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
